// File: rtl/button_conditioner.sv
// Four-button front end for the clock adjust keys: synchronises the raw
// active-low inputs, debounces them into a stable pressed level, and turns
// each press into a single-cycle adjust pulse with hold-to-repeat.
// Opposing buttons of one pair (inc/dec) held together cancel each other.
//
// Handshake note: there is no valid/ready traffic here. Every pulse output
// is a one-cycle strobe that the consumer samples on the next rising edge.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic       inc_min,
  output logic       dec_min,
  output logic       inc_hour,
  output logic       dec_hour,
  output logic [3:0] btn_level,
  output logic [7:0] state_dbg
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  // One extra value of headroom so the debounce counter can hold DEBOUNCE_CYCLES.
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DB_LIMIT    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Inverted at the first flop so that a cleared synchroniser means "released".
  logic [3:0] sync0;
  logic [3:0] sync1;
  logic [3:0] raw_pulse;
  logic       min_ok;
  logic       hour_ok;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 4'b0000;
      sync1 <= 4'b0000;
    end else begin
      sync0 <= ~btn_n;
      sync1 <= sync0;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [CW-1:0] db_cnt;
    logic          level;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] rpt_cnt;
    logic [CW-1:0] rpt_cnt_next;
    logic          pulse;

    // Debounce: count consecutive disagreeing samples, flip the level once
    // the disagreement has persisted long enough.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt <= '0;
        level  <= 1'b0;
      end else if (sync1[i] == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LIMIT) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Press / hold / repeat state register and repeat counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        state   <= state_next;
        rpt_cnt <= rpt_cnt_next;
      end
    end

    // Next-state and pulse decode; a release always wins over a due pulse.
    always_comb begin
      state_next   = state;
      rpt_cnt_next = rpt_cnt;
      pulse        = 1'b0;
      case (state)
        IDLE: begin
          if (level) begin
            pulse        = 1'b1;
            state_next   = HOLD;
            rpt_cnt_next = '0;
          end
        end
        HOLD: begin
          if (!level) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            pulse        = 1'b1;
            state_next   = REPEAT;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!level) begin
            state_next   = IDLE;
            rpt_cnt_next = '0;
          end else if (rpt_cnt == PERIOD_LAST) begin
            pulse        = 1'b1;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end
      endcase
    end

    assign btn_level[i]        = level;
    assign raw_pulse[i]        = pulse;
    assign state_dbg[2*i +: 2] = state;
  end

  // Opposing keys held together cancel; the FSMs keep running underneath.
  assign min_ok  = ~(btn_level[0] & btn_level[1]);
  assign hour_ok = ~(btn_level[2] & btn_level[3]);

  assign inc_min  = raw_pulse[0] & min_ok  & ~rst;
  assign dec_min  = raw_pulse[1] & min_ok  & ~rst;
  assign inc_hour = raw_pulse[2] & hour_ok & ~rst;
  assign dec_hour = raw_pulse[3] & hour_ok & ~rst;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Cycle c means the interval just after the c-th rising edge of a test;
// inputs for edge c are driven before it and outputs are sampled #1 after.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic       inc_min;
  logic       dec_min;
  logic       inc_hour;
  logic       dec_hour;
  logic [3:0] btn_level;
  logic [7:0] state_dbg;

  int checks;
  int errors;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .inc_min  (inc_min),
    .dec_min  (dec_min),
    .inc_hour (inc_hour),
    .dec_hour (dec_hour),
    .btn_level(btn_level),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    btn_n = 4'hF;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    btn_n = 4'b1110;
    rst   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_pulses cycle %0d got %b exp 0000", c, {dec_hour, inc_hour, dec_min, inc_min});
      end
      checks++;
      if (btn_level !== 4'b0000 || state_dbg !== 8'h00) begin
        errors++;
        $display("FAIL reset_state cycle %0d level %b state %h exp level 0000 state 00", c, btn_level, state_dbg);
      end
    end
    // Button still held at release: a full debounce must precede the pulse.
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      exp_p = (c == 6) ? 4'b0001 : 4'b0000;
      exp_l = (c >= 6) ? 4'b0001 : 4'b0000;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== exp_p) begin
        errors++;
        $display("FAIL held_at_release_pulses cycle %0d got %b exp %b", c, {dec_hour, inc_hour, dec_min, inc_min}, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL held_at_release_level cycle %0d got %b exp %b", c, btn_level, exp_l);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      btn_n = (c < 10) ? 4'b1110 : 4'b1111;
      @(posedge clk); #1;
      exp_p = (c == 6) ? 4'b0001 : 4'b0000;
      exp_l = (c >= 6 && c < 16) ? 4'b0001 : 4'b0000;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== exp_p) begin
        errors++;
        $display("FAIL clean_press_pulses cycle %0d got %b exp %b", c, {dec_hour, inc_hour, dec_min, inc_min}, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL clean_press_level cycle %0d got %b exp %b", c, btn_level, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      btn_n = (c < 3 || (c >= 4 && c < 7)) ? 4'b1011 : 4'b1111;
      @(posedge clk); #1;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_pulses cycle %0d got %b exp 0000", c, {dec_hour, inc_hour, dec_min, inc_min});
      end
      checks++;
      if (btn_level !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_level cycle %0d got %b exp 0000", c, btn_level);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [127:0] m;
    logic [3:0]   exp_p;
    logic [3:0]   exp_l;
    m = '0;
    m[6] = 1'b1; m[26] = 1'b1; m[34] = 1'b1; m[42] = 1'b1; m[50] = 1'b1; m[58] = 1'b1;
    do_reset();
    for (int c = 0; c <= 75; c++) begin
      btn_n = (c < 60) ? 4'b1101 : 4'b1111;
      @(posedge clk); #1;
      exp_p = m[c] ? 4'b0010 : 4'b0000;
      exp_l = (c >= 6 && c < 66) ? 4'b0010 : 4'b0000;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== exp_p) begin
        errors++;
        $display("FAIL auto_repeat_pulses cycle %0d got %b exp %b", c, {dec_hour, inc_hour, dec_min, inc_min}, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL auto_repeat_level cycle %0d got %b exp %b", c, btn_level, exp_l);
      end
    end
  endtask

  task automatic test_conflict();
    logic [127:0] m;
    logic [3:0]   exp_p;
    logic [3:0]   exp_l;
    m = '0;
    m[50] = 1'b1; m[58] = 1'b1;
    do_reset();
    for (int c = 0; c <= 75; c++) begin
      btn_n = 4'b1111;
      if (c < 55) btn_n[2] = 1'b0;
      if (c < 40) btn_n[3] = 1'b0;
      @(posedge clk); #1;
      exp_p = m[c] ? 4'b0100 : 4'b0000;
      exp_l = 4'b0000;
      if (c >= 6 && c < 61) exp_l[2] = 1'b1;
      if (c >= 6 && c < 46) exp_l[3] = 1'b1;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== exp_p) begin
        errors++;
        $display("FAIL conflict_pulses cycle %0d got %b exp %b", c, {dec_hour, inc_hour, dec_min, inc_min}, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL conflict_level cycle %0d got %b exp %b", c, btn_level, exp_l);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [127:0] m;
    logic [3:0]   exp_p;
    logic [3:0]   exp_l;
    m = '0;
    m[6] = 1'b1; m[26] = 1'b1; m[37] = 1'b1; m[57] = 1'b1; m[65] = 1'b1; m[73] = 1'b1;
    do_reset();
    for (int c = 0; c <= 90; c++) begin
      btn_n = (c < 75) ? 4'b1110 : 4'b1111;
      rst   = (c == 30);
      @(posedge clk); #1;
      exp_p = m[c] ? 4'b0001 : 4'b0000;
      exp_l = ((c >= 6 && c < 30) || (c >= 37 && c < 81)) ? 4'b0001 : 4'b0000;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== exp_p) begin
        errors++;
        $display("FAIL reset_mid_repeat_pulses cycle %0d got %b exp %b", c, {dec_hour, inc_hour, dec_min, inc_min}, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL reset_mid_repeat_level cycle %0d got %b exp %b", c, btn_level, exp_l);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_independent_pairs();
    logic [3:0] exp_p;
    logic [3:0] exp_l;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      btn_n = (c < 10) ? 4'b1010 : 4'b1111;
      @(posedge clk); #1;
      exp_p = (c == 6) ? 4'b0101 : 4'b0000;
      exp_l = (c >= 6 && c < 16) ? 4'b0101 : 4'b0000;
      checks++;
      if ({dec_hour, inc_hour, dec_min, inc_min} !== exp_p) begin
        errors++;
        $display("FAIL independent_pulses cycle %0d got %b exp %b", c, {dec_hour, inc_hour, dec_min, inc_min}, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        errors++;
        $display("FAIL independent_level cycle %0d got %b exp %b", c, btn_level, exp_l);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    btn_n  = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_conflict();
    test_reset_mid_repeat();
    test_independent_pairs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
